// File: rtl/lcd_temp_ctrl_if.sv
// Write-only HD44780 character LCD bus (8-bit data, RS, RW, E).
interface lcd_temp_ctrl_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    modport master (output lcd_rs, output lcd_rw, output lcd_e, output lcd_data);
    modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_e, input  lcd_data);
endinterface

// File: rtl/lcd_temp_ctrl.sv
// HD44780 LCD sequencer: power-up wait, init commands, then "T=DD.DDC" frames
// built from a packed-BCD temperature snapshot taken on each sample_tick.
module lcd_temp_ctrl #(
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLR_WAIT_CYC   = 100000,
    parameter int unsigned PWRUP_WAIT_CYC = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic [15:0]            bcd_in,
    output logic                   busy,
    lcd_temp_ctrl_if.master        lcd
);

    localparam int unsigned MAX_A = (E_PULSE_CYC > CMD_WAIT_CYC) ? E_PULSE_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_B = (CLR_WAIT_CYC > PWRUP_WAIT_CYC) ? CLR_WAIT_CYC : PWRUP_WAIT_CYC;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;

    typedef enum logic [1:0] {PWRUP, INIT, IDLE, UPD} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            pending_q, pending_d;
    logic [15:0]     snap_q, snap_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;

    logic [CW-1:0]   wait_last;
    logic [3:0]      last_idx;
    logic [3:0]      idx_nxt;

    function automatic logic [7:0] digit(input logic [3:0] n, input logic blank_zero);
        if (blank_zero && n == 4'd0) return 8'h20;
        else if (n > 4'd9)           return 8'h3F;
        else                         return 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [8:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:    return {1'b0, 8'h38};
            4'd1:    return {1'b0, 8'h0C};
            4'd2:    return {1'b0, 8'h06};
            default: return {1'b0, 8'h01};
        endcase
    endfunction

    function automatic logic [8:0] upd_byte(input logic [3:0] i, input logic [15:0] s);
        case (i)
            4'd0:    return {1'b0, 8'h80};
            4'd1:    return {1'b1, 8'h54};
            4'd2:    return {1'b1, 8'h3D};
            4'd3:    return {1'b1, digit(s[15:12], 1'b1)};
            4'd4:    return {1'b1, digit(s[11:8], 1'b0)};
            4'd5:    return {1'b1, 8'h2E};
            4'd6:    return {1'b1, digit(s[7:4], 1'b0)};
            4'd7:    return {1'b1, digit(s[3:0], 1'b0)};
            default: return {1'b1, 8'h43};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PWRUP;
            phase_q   <= SETUP;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            rs_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
        end
    end

    // The clear command alone needs the long settle time after its pulse.
    assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
    assign last_idx  = (state_q == INIT) ? 4'd3 : 4'd8;
    assign idx_nxt   = idx_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        rs_d      = rs_q;
        data_d    = data_q;
        pending_d = pending_q | (sample_tick && state_q != IDLE);

        case (state_q)
            PWRUP: begin
                if (cnt_q == CW'(PWRUP_WAIT_CYC - 1)) begin
                    state_d          = INIT;
                    phase_d          = SETUP;
                    cnt_d            = '0;
                    idx_d            = '0;
                    {rs_d, data_d}   = init_byte(4'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (pending_q || sample_tick) begin
                    snap_d           = bcd_in;
                    pending_d        = 1'b0;
                    state_d          = UPD;
                    phase_d          = SETUP;
                    cnt_d            = '0;
                    idx_d            = '0;
                    {rs_d, data_d}   = upd_byte(4'd0, bcd_in);
                end
            end
            default: begin
                case (phase_q)
                    SETUP: begin
                        phase_d = PULSE;
                        cnt_d   = '0;
                    end
                    PULSE: begin
                        if (cnt_q == CW'(E_PULSE_CYC - 1)) begin
                            phase_d = WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == wait_last) begin
                            cnt_d = '0;
                            if (idx_q == last_idx) begin
                                state_d = IDLE;
                            end else begin
                                idx_d   = idx_nxt;
                                phase_d = SETUP;
                                if (state_q == INIT) {rs_d, data_d} = init_byte(idx_nxt);
                                else                 {rs_d, data_d} = upd_byte(idx_nxt, snap_q);
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        lcd.lcd_rs   = rs_q;
        lcd.lcd_rw   = 1'b0;
        lcd.lcd_data = data_q;
        lcd.lcd_e    = (state_q == INIT || state_q == UPD) && phase_q == PULSE;
        busy         = state_q != IDLE;
    end

endmodule

// File: tb/tb_lcd_temp_ctrl.sv
// Bench for lcd_temp_ctrl: random ticks/temperatures against a timeline model
// predicting every byte's pulse start, value and the busy window.
module tb_lcd_temp_ctrl;

    localparam int unsigned E_P   = 2;
    localparam int unsigned C_W   = 4;
    localparam int unsigned CL_W  = 8;
    localparam int unsigned PW_W  = 10;
    localparam int unsigned BYTE_T  = 1 + E_P + C_W;
    localparam int unsigned INIT_T  = PW_W + 3 * BYTE_T + 1 + E_P + CL_W;
    localparam int unsigned FRAME_T = 9 * BYTE_T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy;

    lcd_temp_ctrl_if lcd ();

    lcd_temp_ctrl #(
        .E_PULSE_CYC    (E_P),
        .CMD_WAIT_CYC   (C_W),
        .CLR_WAIT_CYC   (CL_W),
        .PWRUP_WAIT_CYC (PW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .bcd_in      (bcd_in),
        .busy        (busy),
        .lcd         (lcd)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc;
    int          m_rem;
    bit          m_pend;
    int          tq[$];
    logic [8:0]  bq[$];
    logic        prev_e;
    logic [8:0]  prev_b;
    int          rise_cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ch(input logic [3:0] n, input bit blank);
        if (blank && n == 0) return 8'h20;
        if (n > 9)           return 8'h3F;
        return 8'h30 + {4'h0, n};
    endfunction

    task automatic push_frame(input int base, input logic [15:0] v);
        logic [8:0] b[9];
        b[0] = {1'b0, 8'h80};
        b[1] = {1'b1, 8'h54};
        b[2] = {1'b1, 8'h3D};
        b[3] = {1'b1, ch(v[15:12], 1'b1)};
        b[4] = {1'b1, ch(v[11:8], 1'b0)};
        b[5] = {1'b1, 8'h2E};
        b[6] = {1'b1, ch(v[7:4], 1'b0)};
        b[7] = {1'b1, ch(v[3:0], 1'b0)};
        b[8] = {1'b1, 8'h43};
        for (int k = 0; k < 9; k++) begin
            tq.push_back(base + 1 + k * BYTE_T);
            bq.push_back(b[k]);
        end
    endtask

    task automatic model_reset();
        logic [7:0] ib[4];
        ib[0] = 8'h38; ib[1] = 8'h0C; ib[2] = 8'h06; ib[3] = 8'h01;
        cyc = 0; m_rem = INIT_T; m_pend = 0;
        tq.delete(); bq.delete();
        for (int k = 0; k < 4; k++) begin
            tq.push_back(PW_W + 1 + k * BYTE_T);
            bq.push_back({1'b0, ib[k]});
        end
        prev_e = 1'b0; prev_b = '0; rise_cyc = 0;
    endtask

    // Model: a tick while busy is remembered once; when idle, a tick or the
    // remembered request starts a frame on that edge using the present bcd_in.
    task automatic model_edge(input bit tick, input logic [15:0] v);
        cyc++;
        if (m_rem == 0) begin
            if (tick || m_pend) begin
                push_frame(cyc, v);
                m_rem  = FRAME_T;
                m_pend = 0;
            end
        end else begin
            if (tick) m_pend = 1;
            m_rem--;
        end
    endtask

    task automatic check_now();
        logic [8:0] cur;
        cur = {lcd.lcd_rs, lcd.lcd_data};
        chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
        chk("rw", {31'b0, lcd.lcd_rw}, 0);
        if (cyc < int'(PW_W)) chk("pwrup_bus", {22'b0, lcd.lcd_rs, lcd.lcd_e, lcd.lcd_data}, 0);
        if (lcd.lcd_e && !prev_e) begin
            if (tq.size() == 0) begin
                chk("unexpected_pulse", {23'b0, cur}, 32'h1FF);
            end else begin
                chk("pulse_time", tq[0], cyc);
                chk("byte", {23'b0, cur}, {23'b0, bq[0]});
                chk("setup_byte", {23'b0, prev_b}, {23'b0, bq[0]});
                void'(tq.pop_front());
                void'(bq.pop_front());
            end
            rise_cyc = cyc;
        end
        if (!lcd.lcd_e && prev_e) chk("e_width", cyc - rise_cyc, E_P);
        prev_e = lcd.lcd_e;
        prev_b = cur;
    endtask

    task automatic step(input bit tick, input logic [15:0] v);
        check_now();
        sample_tick = tick;
        bcd_in      = v;
        model_edge(tick, v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sample_tick = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_outputs", {21'b0, busy, lcd.lcd_rs, lcd.lcd_e, lcd.lcd_data}, 32'h400);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] v;
        bit          found;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {21'b0, busy, lcd.lcd_rs, lcd.lcd_e, lcd.lcd_data}, 32'h400);
        rst = 1'b0;
        model_reset();

        // Power-up and init with no ticks.
        for (int i = 0; i < 60; i++) step(1'b0, 16'h0000);

        // Plain frames, including blanked tens and an invalid digit.
        step(1'b1, 16'h2575);
        for (int i = 0; i < 70; i++) step(1'b0, 16'h2575);
        step(1'b1, 16'h0500);
        for (int i = 0; i < 70; i++) step(1'b0, 16'h0500);
        step(1'b1, 16'hA025);
        for (int i = 0; i < 70; i++) step(1'b0, 16'hA025);

        // Several ticks and a new value during a frame collapse into one more frame.
        step(1'b1, 16'h2500);
        for (int i = 1; i < 150; i++)
            step(i == 10 || i == 30 || i == 63, (i >= 5) ? 16'h3125 : 16'h2500);

        // Tick only in the cycle the frame completes.
        step(1'b1, 16'h1234);
        for (int i = 1; i < 150; i++) step(i == 63, (i >= 40) ? 16'h0987 : 16'h1234);

        // Tick during power-up; the value present when idle is reached is shown.
        do_reset();
        for (int i = 0; i < 130; i++)
            step(i == 3, (i >= 30) ? 16'h4321 : 16'h1111);

        // Reset mid-pulse with a request pending; nothing may follow init.
        step(1'b1, 16'h5678);
        for (int i = 1; i < 20; i++) step(i == 5, 16'h5678);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (lcd.lcd_e) found = 1;
            else step(1'b0, 16'h5678);
        end
        chk("e_high_seen", {31'b0, found}, 1);
        do_reset();
        for (int i = 0; i < 80; i++) step(1'b0, 16'h5678);

        // Random ticks and temperatures.
        v = 16'h2200;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) v = 16'($urandom);
            step($urandom_range(0, 39) == 0, v);
        end
        for (int i = 0; i < 150; i++) step(1'b0, v);

        chk("frames_drained", tq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
